flash_arbiter: RTL and testbench
================================

# flash_arbiter

Round-robin arbiter and sequencer for the single weight/bias flash read port. It lets two requesters share the flash: requester 0 is the network controller's weight/bias fetch and requester 1 is the host readback/debug path. It latches the winning address, holds `flash_address`/`flash_ready` stable for the fixed flash access time, captures the returned word, and returns it to the owner with a one-cycle valid pulse. It sits between the requesters and the flash model/macro.

## Interface
- `ADDR_W`, default 16: flash address width.
- `DATA_W`, default 16: flash data width (four 4-bit weights per word).
- `ACCESS_CYCLES`, default 12: cycles `flash_ready` must be held before `flash_data` is valid. Legal range is 1..255.

- `clk`  in  1  system clock.
- `n_rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `req0`  in  1  requester 0 read request; held until `gnt0`.
- `addr0`  in  ADDR_W  requester 0 address; must be valid while `req0` is high.
- `req1`  in  1  requester 1 read request; held until `gnt1`.
- `addr1`  in  ADDR_W  requester 1 address.
- `flash_data`  in  DATA_W  flash read data; valid in the last access cycle.
- `gnt0`, `gnt1`  out  1 each  accept pulse for the request (combinational, IDLE only).
- `valid0`, `valid1`  out  1 each  read-data-valid pulse to the owner.
- `rdata`  out  DATA_W  captured flash word; held until the next capture.
- `flash_address`  out  ADDR_W  latched address driven to flash.
- `flash_ready`  out  1  flash read strobe; high for the whole access.
- `busy`  out  1  high in ACCESS and DONE.

## Operation
- State machine states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not `last_owner`.
  - On a grant: assert the matching `gnt` this cycle, latch `addrN` into the address register, set `owner`, clear `cnt`, and go to ACCESS.
- ACCESS:
  - `flash_ready` = 1 and `flash_address` = latched address. `cnt` increments each cycle.
  - When `cnt == ACCESS_CYCLES-1`: register `flash_data` into `rdata` and go to DONE.
- DONE:
  - `valid[owner]` = 1 for one cycle and `last_owner <= owner`. Go to IDLE.
- Requests raised during ACCESS or DONE are not granted. They wait; no request is lost while it is held.
- `cnt` width is 8 bits; it never wraps within a legal access.
- `flash_address` holds its last latched value outside ACCESS. `flash_ready` is 0 outside ACCESS.
- `gnt0` and `gnt1` are never high together. `valid0` and `valid1` are never high together.
- Reset (`n_rst` low at a rising edge), including mid-access:
  - State goes to IDLE; `cnt`, `rdata`, `flash_address` and `owner` go to 0; `last_owner` goes to 1, so `req0` wins the first tie.
  - No valid pulse is generated for an aborted access. Requesters re-request after reset.
- Output reset values: `gnt*`=0, `valid*`=0, `rdata`=0, `flash_address`=0, `flash_ready`=0, `busy`=0.

## Timing
- Grant at cycle T (IDLE, req high).
- `flash_ready` high in cycles T+1 .. T+ACCESS_CYCLES.
- `rdata` updated at the edge ending T+ACCESS_CYCLES.
- `validN` high in cycle T+ACCESS_CYCLES+1, with `rdata` valid in the same cycle.
- Back-to-back: earliest next grant is T+ACCESS_CYCLES+2, which gives a throughput of one read per ACCESS_CYCLES+2 cycles (14 at the default).
- A requester must keep `req` and `addr` stable until it sees `gnt`. It may drop or change them in the cycle after `gnt`.
- `req` is sampled in the grant cycle; a requester may re-assert `req` in the same cycle as its `valid` pulse.
- `gnt` is a combinational function of the state, the requests and `last_owner`. All other outputs are registered or decoded from state.

## Test plan
- **Reset values:** hold `n_rst`=0 for 2 cycles with `req0`=`req1`=1 -> all outputs 0 and no grant; on release, `gnt0` pulses in the first cycle (tie goes to 0).
- **Single read, default ACCESS_CYCLES=12:** `req0`, `addr0`=0x0040, flash model returns 0xA5C3 at that address -> `gnt0` at T; `flash_address`=0x0040 and `flash_ready`=1 for exactly 12 cycles; `valid0` at T+13 with `rdata`=0xA5C3; `valid1` stays 0.
- **Contention round-robin:** `req0` and `req1` held continuously -> grant order 0,1,0,1, with grants spaced exactly 14 cycles apart and the matching `validN` 13 cycles after each grant.
- **Late request:** `req1` raised 3 cycles after `gnt0`, `req0` dropped -> `gnt1` exactly at the next IDLE (cycle T+14); the `req1` address is latched unchanged.
- **Reset mid-access:** assert `n_rst`=0 at the 6th ACCESS cycle -> next cycle `flash_ready`=0, `busy`=0, `rdata`=0; no `valid` pulse ever appears for that access.
- **ACCESS_CYCLES=1 build:** single `req1` read -> `flash_ready` high for 1 cycle; `valid1` at T+2; back-to-back period of 3 cycles.

Source files
------------

// File: rtl/flash_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared weight/bias flash read port.
// Latches the winning address, holds the flash strobe for ACCESS_CYCLES, returns the word.
module flash_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] flash_data,
  output logic              gnt0,
  output logic              gnt1,
  output logic              valid0,
  output logic              valid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] flash_address,
  output logic              flash_ready,
  output logic              busy
);

  localparam logic [7:0] CntLast = 8'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              grant;
  logic              grant_id;

  // On a tie the requester that did not own the last completed access wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (n_rst && state_q == StIdle) begin
      if (req0 && req1) begin
        grant    = 1'b1;
        grant_id = ~last_owner_q;
      end else if (req0) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (req1) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          addr_d  = grant_id ? addr1 : addr0;
          owner_d = grant_id;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CntLast) begin
          rdata_d = flash_data;
          state_d = StDone;
        end
      end
      StDone: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt0          = grant && !grant_id;
    gnt1          = grant && grant_id;
    flash_ready   = (state_q == StAccess);
    busy          = (state_q != StIdle);
    valid0        = (state_q == StDone) && !owner_q;
    valid1        = (state_q == StDone) && owner_q;
    rdata         = rdata_q;
    flash_address = addr_q;
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter: a default (12-cycle) instance and a 1-cycle instance
// share clock and reset; a per-cycle reference model predicts grants, strobes and read data.
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req0 [2];
  logic        req1 [2];
  logic [15:0] addr0 [2];
  logic [15:0] addr1 [2];
  logic [15:0] flash_data [2];
  logic        gnt0 [2];
  logic        gnt1 [2];
  logic        valid0 [2];
  logic        valid1 [2];
  logic [15:0] rdata [2];
  logic [15:0] flash_address [2];
  logic        flash_ready [2];
  logic        busy [2];

  int acc [2] = '{12, 1};

  typedef struct {
    int          inst;
    int          own;
    logic [15:0] addr;
    int          t;
  } rec_t;

  rec_t sb[$];
  int   cyc = 0;
  bit   rst_edge = 1'b1;
  int   free_cyc [2] = '{0, 0};
  bit   last_m [2] = '{1'b1, 1'b1};
  int   ready_run [2] = '{0, 0};
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  flash_arbiter u_dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req0         (req0[0]),
    .addr0        (addr0[0]),
    .req1         (req1[0]),
    .addr1        (addr1[0]),
    .flash_data   (flash_data[0]),
    .gnt0         (gnt0[0]),
    .gnt1         (gnt1[0]),
    .valid0       (valid0[0]),
    .valid1       (valid1[0]),
    .rdata        (rdata[0]),
    .flash_address(flash_address[0]),
    .flash_ready  (flash_ready[0]),
    .busy         (busy[0])
  );

  flash_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk          (clk),
    .n_rst        (n_rst),
    .req0         (req0[1]),
    .addr0        (addr0[1]),
    .req1         (req1[1]),
    .addr1        (addr1[1]),
    .flash_data   (flash_data[1]),
    .gnt0         (gnt0[1]),
    .gnt1         (gnt1[1]),
    .valid0       (valid0[1]),
    .valid1       (valid1[1]),
    .rdata        (rdata[1]),
    .flash_address(flash_address[1]),
    .flash_ready  (flash_ready[1]),
    .busy         (busy[1])
  );

  function automatic logic [15:0] fmodel(input logic [15:0] a);
    return a ^ 16'hA583;
  endfunction

  // Flash model: word is only correct in the last cycle of a held strobe.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !n_rst;
    for (int k = 0; k < 2; k++) ready_run[k] <= flash_ready[k] ? ready_run[k] + 1 : 0;
  end

  assign flash_data[0] = (flash_ready[0] && ready_run[0] == 11) ? fmodel(flash_address[0])
                                                                : 16'hDEAD;
  assign flash_data[1] = (flash_ready[1] && ready_run[1] == 0) ? fmodel(flash_address[1])
                                                               : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int       idx = -1;
      automatic int       w = 0;
      automatic logic [1:0] eg = 2'b00;
      automatic logic [1:0] ev = 2'b00;
      automatic logic     er = 1'b0;
      automatic logic     eb = 1'b0;
      if (rst_edge) begin
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].inst == k) sb.delete(i);
        free_cyc[k] = 0;
        last_m[k]   = 1'b1;
        check($sformatf("rst_rdata%0d", k), 32'(rdata[k]), 32'h0);
        check($sformatf("rst_faddr%0d", k), 32'(flash_address[k]), 32'h0);
      end
      for (int i = 0; i < sb.size(); i++) if (sb[i].inst == k && idx < 0) idx = i;
      if (idx >= 0) begin
        eb = 1'b1;
        er = (cyc <= sb[idx].t + acc[k]);
        if (er) check($sformatf("faddr%0d", k), 32'(flash_address[k]), 32'(sb[idx].addr));
        if (cyc == sb[idx].t + acc[k] + 1) begin
          ev = (sb[idx].own == 1) ? 2'b10 : 2'b01;
          check($sformatf("rdata%0d", k), 32'(rdata[k]), 32'(fmodel(sb[idx].addr)));
          last_m[k] = (sb[idx].own == 1);
          sb.delete(idx);
        end
      end
      if (n_rst && cyc >= free_cyc[k] && (req0[k] || req1[k])) begin
        w  = (req0[k] && req1[k]) ? (last_m[k] ? 0 : 1) : (req0[k] ? 0 : 1);
        eg = (w == 1) ? 2'b10 : 2'b01;
        sb.push_back('{k, w, (w == 1) ? addr1[k] : addr0[k], cyc});
        free_cyc[k] = cyc + acc[k] + 2;
      end
      check($sformatf("ctl%0d", k),
            32'({gnt1[k], gnt0[k], valid1[k], valid0[k], flash_ready[k], busy[k]}),
            32'({eg, ev, er, eb}));
    end
  end

  task automatic wait_grant(input int k, input int r, input int tmo, output int gc);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    gc   = -1;
    while (!seen && n < tmo) begin
      @(negedge clk);
      n++;
      if ((r == 0) ? gnt0[k] : gnt1[k]) begin
        seen = 1'b1;
        gc   = cyc;
      end
    end
    check($sformatf("gnt%0d_seen_i%0d", r, k), 32'(seen), 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g [4];
    int ga;
    int gb;
    n_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req0[k]  = 1'b0;
      req1[k]  = 1'b0;
      addr0[k] = 16'h0;
      addr1[k] = 16'h0;
    end
    // Reset with both requests high; tie after release must go to requester 0.
    req0[0]  = 1'b1;
    req1[0]  = 1'b1;
    addr0[0] = 16'h0040;
    addr1[0] = 16'h1234;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    wait_grant(0, 0, 1, g[0]);
    for (int i = 1; i < 4; i++) begin
      wait_grant(0, i % 2, 20, g[i]);
      check($sformatf("rr_gap%0d", i), 32'(g[i] - g[i-1]), 32'd14);
    end
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;

    // Single read; address changes right after the grant.
    req0[0]  = 1'b1;
    addr0[0] = 16'h0040;
    wait_grant(0, 0, 5, ga);
    req0[0]  = 1'b0;
    addr0[0] = 16'hFFFF;
    repeat (14) @(posedge clk);
    #1;
    check("rd_a5c3", 32'(rdata[0]), 32'hA5C3);

    // Late request from requester 1.
    req0[0]  = 1'b1;
    addr0[0] = 16'h0100;
    wait_grant(0, 0, 5, ga);
    req0[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req1[0]  = 1'b1;
    addr1[0] = 16'h0BEE;
    wait_grant(0, 1, 20, gb);
    check("late_gap", 32'(gb - ga), 32'd14);
    req1[0]  = 1'b0;
    addr1[0] = 16'h5555;
    repeat (16) @(posedge clk);
    #1;

    // Reset during the 6th access cycle.
    req0[0]  = 1'b1;
    addr0[0] = 16'h0200;
    wait_grant(0, 0, 5, ga);
    req0[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    check("midrst_rdata", 32'(rdata[0]), 32'h0);
    repeat (20) @(posedge clk);
    #1;

    // One-cycle access instance, back-to-back reads from requester 1.
    req1[1]  = 1'b1;
    addr1[1] = 16'h0777;
    wait_grant(1, 1, 5, ga);
    wait_grant(1, 1, 5, gb);
    check("b2b_gap1", 32'(gb - ga), 32'd3);
    wait_grant(1, 1, 5, ga);
    check("b2b_gap2", 32'(ga - gb), 32'd3);
    req1[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
